// File: rtl/quant_block_scheduler.sv
// Shares one FP multiplier and coefficient-table pair between the Y/Cb/Cr streams,
// granting whole 64-beat blocks round-robin and re-tagging the delayed products.
module quant_block_scheduler #(
  parameter int unsigned DW      = 32,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [2:0]        in_valid,
  input  logic [3*DW-1:0]   in_data,
  output logic [2:0]        in_ready,
  input  logic              mode,
  output logic [1:0]        tbl_sel,
  output logic [2:0]        tbl_row,
  output logic [2:0]        tbl_col,
  output logic [DW-1:0]     mul_a,
  input  logic [DW-1:0]     mul_res,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [1:0]        out_chan,
  output logic [5:0]        out_idx,
  output logic              out_last,
  output logic [2:0]        grant,
  output logic              busy
);

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned CHAN_W = 2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nx;
  logic [2:0]        grant_q, grant_nx;
  logic [CHAN_W-1:0] ptr_q, ptr_nx;
  logic              mode_q, mode_nx;
  logic [IDX_W-1:0]  cnt_q, cnt_nx;
  logic [CHAN_W-1:0] chan_c;
  logic [CHAN_W-1:0] win_c;
  logic              beat_c;
  logic              is_busy;

  logic              pv    [MUL_LAT];
  logic [CHAN_W-1:0] pchan [MUL_LAT];
  logic [IDX_W-1:0]  pidx  [MUL_LAT];
  logic              plast [MUL_LAT];

  // First requesting channel after ptr in Y->Cb->Cr order; the channel at ptr comes last.
  function automatic logic [CHAN_W-1:0] rr_pick(input logic [CHAN_W-1:0] ptr, input logic [2:0] r);
    logic [CHAN_W-1:0] w;
    int unsigned       i;
    w = ptr;
    for (int unsigned k = 3; k >= 1; k--) begin
      i = (32'(ptr) + k) % 3;
      if (r[i]) w = CHAN_W'(i);
    end
    return w;
  endfunction

  always_comb begin
    chan_c = 2'd0;
    if (grant_q[1]) chan_c = 2'd1;
    if (grant_q[2]) chan_c = 2'd2;
  end

  assign is_busy = (state == BUSY);
  assign win_c   = rr_pick(ptr_q, req);
  assign beat_c  = is_busy && ((in_valid & grant_q) != 3'b000);

  assign busy     = is_busy;
  assign grant    = grant_q;
  assign in_ready = is_busy ? grant_q : 3'b000;
  assign tbl_sel  = is_busy ? {mode_q, grant_q[1] | grant_q[2]} : 2'b00;
  assign tbl_row  = cnt_q[2:0];
  assign tbl_col  = cnt_q[5:3];
  assign mul_a    = is_busy ? in_data[32'(chan_c)*DW +: DW] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= 3'b000;
      ptr_q   <= 2'd2;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      grant_q <= grant_nx;
      ptr_q   <= ptr_nx;
      mode_q  <= mode_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Grant on any request from IDLE; on the final beat re-grant in the same edge or drop to IDLE.
  always_comb begin
    state_nx = state;
    grant_nx = grant_q;
    ptr_nx   = ptr_q;
    mode_nx  = mode_q;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE: begin
        if (req != 3'b000) begin
          state_nx = BUSY;
          grant_nx = 3'(1) << win_c;
          ptr_nx   = win_c;
          mode_nx  = mode;
          cnt_nx   = '0;
        end
      end
      BUSY: begin
        if (beat_c) begin
          cnt_nx = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(63)) begin
            if (req != 3'b000) begin
              grant_nx = 3'(1) << win_c;
              ptr_nx   = win_c;
              mode_nx  = mode;
            end else begin
              state_nx = IDLE;
              grant_nx = 3'b000;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Tag pipeline matching the external multiply + table latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MUL_LAT); i++) begin
        pv[i]    <= 1'b0;
        pchan[i] <= '0;
        pidx[i]  <= '0;
        plast[i] <= 1'b0;
      end
    end else begin
      pv[0]    <= beat_c;
      pchan[0] <= chan_c;
      pidx[0]  <= cnt_q;
      plast[0] <= (cnt_q == IDX_W'(63));
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        pv[i]    <= pv[i-1];
        pchan[i] <= pchan[i-1];
        pidx[i]  <= pidx[i-1];
        plast[i] <= plast[i-1];
      end
    end
  end

  assign out_valid = pv[MUL_LAT-1];
  assign out_chan  = pchan[MUL_LAT-1];
  assign out_idx   = pidx[MUL_LAT-1];
  assign out_last  = plast[MUL_LAT-1];
  assign out_data  = mul_res;

endmodule

// File: tb/tb_quant_block_scheduler.sv
// Bench for quant_block_scheduler: block-level arbitration model plus a result
// scoreboard, with a stand-in multiplier/table on the external product path.
module tb_quant_block_scheduler;
  localparam int unsigned DW      = 32;
  localparam int unsigned MUL_LAT = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req;
  logic [2:0]      in_valid;
  logic [3*DW-1:0] in_data;
  logic [2:0]      in_ready;
  logic            mode;
  logic [1:0]      tbl_sel;
  logic [2:0]      tbl_row;
  logic [2:0]      tbl_col;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_res;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_chan;
  logic [5:0]      out_idx;
  logic            out_last;
  logic [2:0]      grant;
  logic            busy;

  quant_block_scheduler #(.DW(DW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mode(mode), .tbl_sel(tbl_sel), .tbl_row(tbl_row),
    .tbl_col(tbl_col), .mul_a(mul_a), .mul_res(mul_res), .out_valid(out_valid),
    .out_data(out_data), .out_chan(out_chan), .out_idx(out_idx),
    .out_last(out_last), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in product: the step table scales by 16, the reciprocal table by 0.5,
  // and each table entry adds a distinct mantissa tag {chroma,col,row}.
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [1:0] sel,
                                            input logic [2:0] row, input logic [2:0] col);
    logic [31:0] bump;
    bump = sel[1] ? 32'h0200_0000 : 32'hFF80_0000;
    return a + bump + (32'({sel[0], col, row}) << 8);
  endfunction

  logic [31:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_model(mul_a, tbl_sel, tbl_row, tbl_col);
    for (int i = 1; i < int'(MUL_LAT); i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_res = mpipe[MUL_LAT-1];

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  ch;
    logic [5:0]  idx;
    logic        last;
  } res_t;

  res_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   mptr     = 2;
  int   busy_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // One traffic scenario: p[c] blocks queued per channel, vmode 0=no gaps 1=1,0,0 2=random.
  task automatic run_scn(input int p0, input int p1, input int p2, input logic md,
                         input int vmode, input bit flip, input int rst_at, input bit fixed2);
    int          tmp [3];
    int          live[3];
    int          wr  [3];
    int          rd  [3];
    logic [31:0] src [3][256];
    int          beats;
    int          budget;
    bit          done;
    bit          seen;
    int          c;
    res_t        e;
    logic [31:0] d;
    tmp[0] = p0; tmp[1] = p1; tmp[2] = p2;
    live = tmp;
    for (int k = 0; k < 3; k++) begin wr[k] = 0; rd[k] = 0; end
    // Expected block order: round-robin over pending counts, starting after the last winner.
    while (tmp[0] + tmp[1] + tmp[2] > 0) begin
      c = -1;
      for (int k = 1; k <= 3 && c < 0; k++)
        if (tmp[(mptr + k) % 3] > 0) c = (mptr + k) % 3;
      tmp[c]--;
      mptr = c;
      for (int b = 0; b < 64; b++) begin
        d = fixed2 ? 32'h4000_0000 : rnd_fp();
        src[c][wr[c]] = d;
        wr[c]++;
        e.d    = mul_model(d, {md, 1'(c != 0)}, 3'(b % 8), 3'(b / 8));
        e.ch   = 2'(c);
        e.idx  = 6'(b);
        e.last = (b == 63);
        exp_q.push_back(e);
      end
    end
    budget   = (p0 + p1 + p2) * 64 * 4 + 40;
    beats    = 0;
    busy_cyc = 0;
    done     = 0;
    seen     = 0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk);
      if (rst_at > 0 && beats == rst_at) begin
        rst = 1'b1; req = 3'b000; in_valid = 3'b000;
        #1;
        chk("rst_midblock", 64'({out_valid, grant, busy}), 64'd0);
        exp_q.delete();
        mptr = 2;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("result", 64'({out_data, out_chan, out_idx, out_last}), 64'(e));
          if (fixed2 && !seen) begin
            chk("first_product", 64'({out_data, out_idx}), 64'({32'h4200_0000, 6'd0}));
            seen = 1;
          end
        end
      end
      if (busy) begin
        busy_cyc++;
        chk("ready_onehot", 64'($onehot(in_ready)), 64'd1);
      end else begin
        chk("idle_ready", 64'({grant, in_ready}), 64'd0);
      end
      if (exp_q.size() == 0 && !busy && live[0] + live[1] + live[2] == 0) begin
        done = 1;
      end else begin
        for (int k = 0; k < 3; k++) begin
          bit gate;
          req[k] = (live[k] > 0);
          case (vmode)
            0:       gate = 1'b1;
            1:       gate = (cyc % 3 == 0);
            default: gate = 1'($urandom_range(0, 1));
          endcase
          in_valid[k] = (rd[k] < wr[k]) && gate;
          in_data[k*DW +: DW] = (rd[k] < wr[k]) ? src[k][rd[k]] : $urandom;
        end
        mode = (flip && beats >= 10) ? ~md : md;
        #1;
        for (int k = 0; k < 3; k++) begin
          if (in_valid[k] && in_ready[k]) begin
            if (rd[k] % 64 == 0) live[k]--;
            rd[k]++;
            beats++;
          end
        end
      end
    end
    chk("scenario_done", 64'(done), 64'd1);
    chk("idle_after", 64'({busy, grant}), 64'd0);
    req = 3'b000; in_valid = 3'b000;
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; in_valid = 3'b000; in_data = '0; mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_values", 64'({in_ready, grant, busy, tbl_sel, tbl_row, tbl_col,
                             out_valid, out_chan, out_idx, out_last}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Three simultaneous blocks: Y, Cb, Cr back-to-back in 192 busy cycles.
    run_scn(1, 1, 1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
    chk("busy_cycles_3blk", 64'(busy_cyc), 64'd192);

    // Single Y block of 2.0 in step-table mode.
    run_scn(1, 0, 0, 1'b1, 0, 0, 0, 1);

    // Y with 1,0,0 valid gaps.
    run_scn(1, 0, 0, 1'b0, 1, 0, 0, 0);

    // Cr block with mode flipped mid-block.
    run_scn(0, 0, 1, 1'b0, 2, 1, 0, 0);

    // Y holds two blocks while Cr requests once: Y, Cr, Y.
    run_scn(2, 0, 1, 1'b1, 2, 0, 0, 0);

    // Randomized mixes.
    for (int r = 0; r < 3; r++) begin
      int a, b, c;
      a = $urandom_range(0, 2); b = $urandom_range(0, 2); c = $urandom_range(1, 2);
      run_scn(a, b, c, 1'($urandom_range(0, 1)), 2, 0, 0, 0);
    end

    // Reset at beat 30 of a Cb block, then Y and Cb restart with Y first.
    run_scn(0, 1, 0, 1'b0, 0, 0, 30, 0);
    run_scn(1, 1, 0, 1'($urandom_range(0, 1)), 2, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
